// File: rtl/pipe_ctrl_if.sv
// Control-unit bus: decode inputs and hazard/flag inputs towards the unit, control outputs back.
// The unit binds to the slave modport; the datapath/hazard side uses master.
interface pipe_ctrl_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  stallE;
    logic                  flushE;
    logic                  zeroE;
    logic                  ltE;
    logic                  ltuE;
    logic [2:0]            imm_srcD;
    logic                  illegal_instrD;
    logic [ALU_CTRL_W-1:0] alu_controlE;
    logic                  alu_srcE;
    logic                  alu_src_aE;
    logic                  pc_srcE;
    logic                  pc_target_srcE;
    logic                  result_srcE0;
    logic                  reg_writeM;
    logic                  mem_writeM;
    logic                  reg_writeW;
    logic [1:0]            result_srcW;

    modport master (
        output op, funct3, funct7, stallE, flushE, zeroE, ltE, ltuE,
        input  imm_srcD, illegal_instrD, alu_controlE, alu_srcE, alu_src_aE,
        input  pc_srcE, pc_target_srcE, result_srcE0, reg_writeM, mem_writeM,
        input  reg_writeW, result_srcW
    );

    modport slave (
        input  op, funct3, funct7, stallE, flushE, zeroE, ltE, ltuE,
        output imm_srcD, illegal_instrD, alu_controlE, alu_srcE, alu_src_aE,
        output pc_srcE, pc_target_srcE, result_srcE0, reg_writeM, mem_writeM,
        output reg_writeW, result_srcW
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// RV32I 5-stage pipeline control: decode in D, control word carried through E, M and W.
// Define PIPE_CTRL_FULL_BRANCH_EN to accept all six conditional branches (default: beq only).
module pipe_ctrl_unit #(
    parameter int ALU_CTRL_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_BAD   = 4'b1111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       rw;
        logic [1:0] res;
        logic       mw;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic [2:0] funct3;
        logic [3:0] alu;
        logic       src_a;
        logic       src_b;
    } ctrl_e_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] res;
        logic       mw;
    } ctrl_m_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] res;
    } ctrl_w_t;

    ctrl_e_t    dec;
    ctrl_e_t    e_q;
    ctrl_m_t    m_q;
    ctrl_w_t    w_q;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] r_alu;
    logic [3:0] i_alu;
    logic       r_legal;
    logic       br_legal;
    logic       taken;

    // funct7[5] selects sub/sra for R-type; for I-type only the shift-right case reaches it.
    always_comb begin
        r_alu = ALU_BAD;
        case (bus.funct3)
            3'b000:  r_alu = bus.funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  r_alu = ALU_SLL;
            3'b010:  r_alu = ALU_SLT;
            3'b011:  r_alu = ALU_SLTU;
            3'b100:  r_alu = ALU_XOR;
            3'b101:  r_alu = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  r_alu = ALU_OR;
            default: r_alu = ALU_AND;
        endcase
    end

    assign i_alu   = (bus.funct3 == 3'b000) ? ALU_ADD : r_alu;
    assign r_legal = (bus.funct7 == 7'b0000000) ||
                     ((bus.funct7 == 7'b0100000) &&
                      ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));

`ifdef PIPE_CTRL_FULL_BRANCH_EN
    assign br_legal = (bus.funct3[2:1] != 2'b01);

    always_comb begin
        taken = 1'b0;
        case (e_q.funct3)
            3'b000:  taken = bus.zeroE;
            3'b001:  taken = ~bus.zeroE;
            3'b100:  taken = bus.ltE;
            3'b101:  taken = ~bus.ltE;
            3'b110:  taken = bus.ltuE;
            3'b111:  taken = ~bus.ltuE;
            default: taken = 1'b0;
        endcase
    end
`else
    assign br_legal = (bus.funct3 == 3'b000);
    assign taken    = bus.zeroE;

    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{bus.ltE, bus.ltuE, e_q.funct3};
`endif

    always_comb begin
        dec        = '0;
        dec.funct3 = bus.funct3;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        case (bus.op)
            OP_LOAD: begin
                if (bus.funct3 == 3'b010) begin
                    dec.rw    = 1'b1;
                    dec.res   = RES_MEM;
                    dec.src_b = 1'b1;
                    dec.alu   = ALU_ADD;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (bus.funct3 == 3'b010) begin
                    dec.mw    = 1'b1;
                    dec.src_b = 1'b1;
                    dec.alu   = ALU_ADD;
                    imm_src   = IMM_S;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_REG: begin
                if (r_legal) begin
                    dec.rw  = 1'b1;
                    dec.alu = r_alu;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.rw    = 1'b1;
                dec.src_b = 1'b1;
                dec.alu   = i_alu;
            end
            OP_BRANCH: begin
                if (br_legal) begin
                    dec.branch = 1'b1;
                    dec.alu    = ALU_SUB;
                    imm_src    = IMM_B;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JAL: begin
                dec.rw   = 1'b1;
                dec.jump = 1'b1;
                dec.res  = RES_PC4;
                imm_src  = IMM_J;
            end
            OP_JALR: begin
                if (bus.funct3 == 3'b000) begin
                    dec.rw    = 1'b1;
                    dec.jump  = 1'b1;
                    dec.jalr  = 1'b1;
                    dec.src_b = 1'b1;
                    dec.alu   = ALU_ADD;
                    dec.res   = RES_PC4;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LUI: begin
                dec.rw    = 1'b1;
                dec.src_b = 1'b1;
                dec.alu   = ALU_PASSB;
                imm_src   = IMM_U;
            end
            OP_AUIPC: begin
                dec.rw    = 1'b1;
                dec.src_a = 1'b1;
                dec.src_b = 1'b1;
                dec.alu   = ALU_ADD;
                imm_src   = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        // An illegal word must never write state or redirect fetch.
        if (illegal) begin
            dec     = '0;
            dec.alu = ALU_BAD;
            imm_src = IMM_I;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!bus.stallE) begin
            e_q <= bus.flushE ? '0 : dec;
            m_q <= '{rw: e_q.rw, res: e_q.res, mw: e_q.mw};
            w_q <= '{rw: m_q.rw, res: m_q.res};
        end
    end

    assign bus.imm_srcD       = imm_src;
    assign bus.illegal_instrD = illegal;
    assign bus.alu_controlE   = ALU_CTRL_W'(e_q.alu);
    assign bus.alu_srcE       = e_q.src_b;
    assign bus.alu_src_aE     = e_q.src_a;
    assign bus.pc_srcE        = e_q.jump | (e_q.branch & taken);
    assign bus.pc_target_srcE = e_q.jalr;
    assign bus.result_srcE0   = e_q.res[0];
    assign bus.reg_writeM     = m_q.rw;
    assign bus.mem_writeM     = m_q.mw;
    assign bus.reg_writeW     = w_q.rw;
    assign bus.result_srcW    = w_q.res;
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised 5-stage pipeline control unit for the RV32I core. It decodes opcode, funct3 and funct7 in Decode and carries the control word through the D→E, E→M and M→W pipeline registers. Compared with the previous control unit it adds:
- hazard flush (bubble insertion) and stall;
- U-type and JALR decode;
- PC-relative operand select;
- illegal-instruction flagging;
- optional full conditional-branch set.

It sits beside the datapath and hazard unit; its outputs drive muxes and write enables.

## Interface
- `ALU_CTRL_W`, 4: ALU control width; must be ≥ 4, and upper bits beyond 4 are zero.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `op` in 7: instruction[6:0] in D.
- `funct3` in 3: instruction[14:12] in D.
- `funct7` in 7: instruction[31:25] in D.
- `stallE` in 1: hold the E, M and W control registers.
- `flushE` in 1: load a bubble into the E control register.
- `zeroE` in 1: ALU result == 0.
- `ltE` in 1: signed rs1 < rs2.
- `ltuE` in 1: unsigned rs1 < rs2.
- `imm_srcD` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `illegal_instrD` out 1: unsupported encoding in D.
- `alu_controlE` out `ALU_CTRL_W`: ALU operation.
- `alu_srcE` out 1: ALU B operand; 1 selects the immediate.
- `alu_src_aE` out 1: ALU A operand; 1 selects PC (auipc).
- `pc_srcE` out 1: redirect fetch.
- `pc_target_srcE` out 1: 1 selects the ALU result (jalr), 0 selects PC+imm.
- `result_srcE0` out 1: `result_srcE[0]`, load-use detect.
- `reg_writeM` out 1: forwarding qualifier.
- `mem_writeM` out 1: data memory write enable.
- `reg_writeW` out 1: register file write enable.
- `result_srcW` out 2: 00 ALU, 01 mem, 10 PC+4.

## Operation
- Decode is combinational. Control word fields per instruction class:
  - lw (0000011, funct3 010): rw=1, imm I, srcB=1, res=01, ALU add.
  - sw (0100011, funct3 010): mw=1, imm S, srcB=1, ALU add.
  - R (0110011): rw=1, srcB=0, ALU from funct3/funct7[5]. funct7 must be 0000000, or 0100000 for sub/sra only.
  - I-ALU (0010011): rw=1, imm I, srcB=1. funct7[5] is honoured only for srai.
  - branch (1100011): branch=1, imm B, ALU sub.
  - jal (1101111): rw=1, jump=1, imm J, res=10.
  - jalr (1100111, funct3 000): rw=1, jump=1, jalr=1, imm I, srcB=1, ALU add, res=10.
  - lui (0110111): rw=1, imm U, srcB=1, ALU passB.
  - auipc (0010111): rw=1, imm U, srcA=1, srcB=1, ALU add.
- ALU encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
  - 1010 passB, 1111 invalid
- Any other encoding: `illegal_instrD`=1, all write enables 0, jump/branch 0, ALU 1111.
- The E register stores rw, res, mw, jump, branch, jalr, funct3, alu_control, srcA and srcB.
- `pc_srcE` = jumpE | (branchE & taken). `taken` is decoded from funct3E (see Configuration).
- `pc_target_srcE` = jalrE.

## Timing
- Latency: D decode → E outputs 1 cycle; → M 2 cycles; → W 3 cycles.
- Reset: at any rising edge with `rst_n`=0, all pipeline registers clear. Every registered output reads 0 from the next cycle. `pc_srcE`=0 and `result_srcE0`=0.
- `imm_srcD` and `illegal_instrD` are combinational and follow the inputs. They are not reset.
- Priority at each edge: `rst_n` > `stallE` > `flushE` > normal load.
- `stallE`=1 holds E, M and W. `flushE` is ignored while stalled.
- `flushE`=1 without stall loads an all-zero bubble into E. M and W advance normally. The bubble yields `pc_srcE`=0 in the following cycle.
- Mid-operation reset discards all in-flight control. There is no partial retirement.
- `pc_srcE` is combinational from E registers and flags, so it is valid in the same cycle as the E stage.

## Configuration
- `PIPE_CTRL_FULL_BRANCH_EN` defined:
  - Branch funct3 values 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu are legal.
  - `taken` per funct3: zeroE, ~zeroE, ltE, ~ltE, ltuE, ~ltuE.
  - funct3 010/011 are illegal.
- Undefined:
  - Only beq (funct3 000) is legal, and `taken` = zeroE.
  - Other branch funct3 values assert `illegal_instrD`.
  - `ltE` and `ltuE` are ignored.

## Test plan
- Reset, then op=0110011 f3=000 f7=0100000 (sub).
  - Next cycle: `alu_controlE`=0001, `alu_srcE`=0.
  - 3 cycles after decode: `reg_writeW`=1, `result_srcW`=00.
- lw (0000011/010) with `flushE`=1 on its D→E edge.
  - `result_srcE0`=0 and `reg_writeM`=0 one cycle later.
  - Same lw without flush: `result_srcE0`=1, then `result_srcW`=01 at W.
- jalr (1100111/000): `imm_srcD`=000; next cycle `pc_srcE`=1, `pc_target_srcE`=1, `alu_controlE`=0000; `result_srcW`=10 at W.
- Branch, f3=001 (bne), zeroE=0.
  - With macro: `pc_srcE`=1.
  - Without macro: `illegal_instrD`=1 and `pc_srcE`=0.
- lui then auipc back-to-back.
  - `imm_srcD`=100 for both.
  - lui in E: `alu_controlE`=1010, `alu_src_aE`=0.
  - auipc in E next cycle: `alu_controlE`=0000, `alu_src_aE`=1.
- sw in E with `stallE`=1 for 2 cycles: `mem_writeM` keeps its prior value; `mem_writeM`=1 the cycle after stall release. `rst_n`=0 asserted during the stall clears all outputs at the next edge.
